// File: rtl/siso_ctrl_pkg.sv
// Shared definitions for the SISO chain controller: FSM state encoding and
// default geometry of the serial word and the external chain.
package siso_ctrl_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/siso_ctrl_rr_arb2.sv
// Two-way round-robin arbiter. The grant is combinational from req and the
// pointer; the pointer only moves when the caller accepts a grant, so a
// request that is never acted on does not disturb fairness.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  // pref_q = 1 means requester 1 wins a tie; 0 (reset) favours requester 0.
  logic pref_q;
  logic pref_d;

  // Grant selection: single requester wins outright, a tie goes to pref_q.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = pref_q ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // Pointer update: after serving one requester, prefer the other.
  always_comb begin
    pref_d = pref_q;
    if (accept && (gnt != 2'b00)) begin
      pref_d = gnt[0];
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pref_q <= 1'b0;
    end else begin
      pref_q <= pref_d;
    end
  end

endmodule

// File: rtl/siso_ctrl.sv
// Controller that serialises a granted requester's word into an external
// DEPTH-stage SISO chain (LSB first) and recovers the word from the chain
// output. One transaction: IDLE (grant) -> SHIFT (WIDTH+DEPTH cycles) ->
// DONE (one cycle) -> IDLE.
//
// Handshake: req[i] is a level request that the requester holds until it
// sees done; the controller samples req only in IDLE, so a request dropped
// mid-transaction does not abort it. gnt is one-hot from the grant edge
// through the DONE cycle and data is captured exactly at the grant edge.
module siso_ctrl
  import siso_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             shift_en,
  output logic             sdo,
  input  logic             sdi,
  output logic [WIDTH-1:0] rx_data,
  output logic             done
);

  localparam int TOTAL = WIDTH + DEPTH;
  localparam int CW    = $clog2(TOTAL + 1);

  localparam logic [CW-1:0] LAST_K  = CW'(TOTAL - 1);
  localparam logic [CW-1:0] FIRST_RX = CW'(DEPTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       arb_gnt;
  logic             arb_accept;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .accept (arb_accept),
    .gnt    (arb_gnt)
  );

  // Next-state and datapath: grant/latch in IDLE, shift both registers in
  // SHIFT, release the grant after DONE.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    gnt_d      = gnt_q;
    arb_accept = 1'b0;
    case (state_q)
      ST_IDLE: begin
        gnt_d = 2'b00;
        if (req != 2'b00) begin
          arb_accept = 1'b1;
          gnt_d      = arb_gnt;
          tx_d       = arb_gnt[1] ? data1 : data0;
          rx_d       = '0;
          cnt_d      = '0;
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Zeros fill in behind the word, so sdo is 0 once k >= WIDTH.
        tx_d = tx_q >> 1;
        // The chain delays sdo by DEPTH cycles; capture MSB-first into the
        // top so that the first captured bit lands in bit 0 at the end.
        if (cnt_q >= FIRST_RX) begin
          rx_d = WIDTH'({sdi, rx_q} >> 1);
        end
        if (cnt_q == LAST_K) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        gnt_d   = 2'b00;
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = 2'b00;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      gnt_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      gnt_q   <= gnt_d;
    end
  end

  assign gnt      = gnt_q;
  assign busy     = (state_q != ST_IDLE);
  assign shift_en = (state_q == ST_SHIFT);
  assign sdo      = shift_en & tx_q[0];
  assign done     = (state_q == ST_DONE);
  assign rx_data  = rx_q;

endmodule

// File: tb/tb_siso_ctrl.sv
// Loopback bench for siso_ctrl: a DEPTH-stage chain model feeds sdo back to
// sdi. Expected grants and words are pushed when a request is driven and
// popped when the controller signals done.
`timescale 1ns/1ps
module tb_siso_ctrl;
  import siso_ctrl_pkg::*;

  localparam int W  = 4;
  localparam int D  = 4;
  localparam int D1 = 1;
  localparam int TO = 200;

  // ---------------- clock / reset / signals ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req;
  logic [W-1:0] data0, data1;
  logic [1:0]   gnt;
  logic         busy, shift_en, sdo, sdi, done;
  logic [W-1:0] rx_data;

  logic [1:0]   req1;
  logic [W-1:0] data1_0, data1_1;
  logic [1:0]   gnt1;
  logic         busy1, shift_en1, sdo1, sdi1, done1;
  logic [W-1:0] rx1;

  logic [D-1:0] chain  = '0;
  logic         chain1 = 1'b0;

  always #5 clk = ~clk;

  siso_ctrl #(.WIDTH(W), .DEPTH(D)) u_dut (
    .clk(clk), .rst(rst), .req(req), .data0(data0), .data1(data1),
    .gnt(gnt), .busy(busy), .shift_en(shift_en), .sdo(sdo), .sdi(sdi),
    .rx_data(rx_data), .done(done)
  );

  siso_ctrl #(.WIDTH(W), .DEPTH(D1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req1), .data0(data1_0), .data1(data1_1),
    .gnt(gnt1), .busy(busy1), .shift_en(shift_en1), .sdo(sdo1), .sdi(sdi1),
    .rx_data(rx1), .done(done1)
  );

  // External SISO chain models; they are not touched by rst.
  always @(posedge clk) if (shift_en) chain <= {chain[D-2:0], sdo};
  assign sdi = chain[D-1];
  always @(posedge clk) if (shift_en1) chain1 <= sdo1;
  assign sdi1 = chain1;

  // ---------------- protocol properties ----------------
  assert property (@(posedge clk) disable iff (rst) $onehot0(gnt))
    else $error("gnt not one-hot or zero");
  assert property (@(posedge clk) disable iff (rst) done |=> !done)
    else $error("done longer than one cycle");
  assert property (@(posedge clk) disable iff (rst) shift_en == (busy && !done))
    else $error("shift_en does not track SHIFT state");
  assert property (@(posedge clk) disable iff (rst) $onehot0(gnt1))
    else $error("gnt1 not one-hot or zero");
  assert property (@(posedge clk) disable iff (rst) done1 |=> !done1)
    else $error("done1 longer than one cycle");

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- scoreboard and reference arbiter ----------------
  logic [W-1:0] exp_q[$];
  logic [1:0]   exp_gnt_q[$];
  logic         model_pref = 1'b0;

  function automatic logic [1:0] model_arb(input logic [1:0] r, input logic pref);
    if (r == 2'b11) return pref ? 2'b10 : 2'b01;
    return r;
  endfunction

  task automatic push_txn(input logic [1:0] r, input logic [W-1:0] d0, input logic [W-1:0] d1);
    logic [1:0] g;
    g = model_arb(r, model_pref);
    exp_gnt_q.push_back(g);
    exp_q.push_back(g[1] ? d1 : d0);
    model_pref = g[0];
  endtask

  // ---------------- monitor ----------------
  int             cyc = 0;
  int             grant_cyc = 0;
  int             last_done_cyc = 0;
  int             n_grants = 0;
  int             n_dones = 0;
  int             sdo_n = 0;
  logic [1:0]     gnt_prev = 2'b00;
  logic [W+D-1:0] sdo_cap = '0;
  logic           chk_gap = 1'b0;
  logic [W-1:0]   ew;
  logic [1:0]     eg;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      gnt_prev = 2'b00;
      sdo_n    = 0;
    end else begin
      if (gnt != 2'b00 && gnt_prev == 2'b00) begin
        n_grants++;
        grant_cyc = cyc;
        sdo_n     = 0;
        check("grant_expected", 32'(exp_gnt_q.size() > 0), 32'd1);
        if (exp_gnt_q.size() > 0) check("gnt_at_grant", 32'(gnt), 32'(exp_gnt_q[0]));
        if (chk_gap && n_dones > 0) check("idle_gap", 32'(cyc - last_done_cyc), 32'd2);
      end
      if (shift_en) begin
        sdo_cap = {sdo, sdo_cap[W+D-1:1]};
        sdo_n++;
      end
      if (done) begin
        n_dones++;
        check("latency", 32'(cyc - grant_cyc + 1), 32'(W + D + 1));
        check("shift_cycles", 32'(sdo_n), 32'(W + D));
        check("done_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          ew = exp_q.pop_front();
          eg = exp_gnt_q.pop_front();
          check("rx_data", 32'(rx_data), 32'(ew));
          check("gnt_at_done", 32'(gnt), 32'(eg));
          check("sdo_seq", 32'(sdo_cap), 32'({{D{1'b0}}, ew}));
        end
        last_done_cyc = cyc;
      end
      gnt_prev = gnt;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_grants(input int n);
    int t;
    t = 0;
    while (n_grants < n && t < TO) begin step(1); t++; end
    check("grant_timeout", 32'(n_grants), 32'(n));
  endtask

  task automatic wait_dones(input int n);
    int t;
    t = 0;
    while (n_dones < n && t < TO) begin step(1); t++; end
    check("done_timeout", 32'(n_dones), 32'(n));
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = 2'b00;
    req1 = 2'b00;
    step(2);
    exp_q.delete();
    exp_gnt_q.delete();
    model_pref = 1'b0;
    n_grants   = 0;
    n_dones    = 0;
    rst        = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int t;
    logic [1:0]   r;
    logic [W-1:0] rd0, rd1;

    rst = 1'b1; req = 2'b00; data0 = '0; data1 = '0;
    req1 = 2'b00; data1_0 = '0; data1_1 = '0;
    step(3);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_shift_en", 32'(shift_en), 32'd0);
    check("rst_sdo", 32'(sdo), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    rst = 1'b0;
    step(1);

    // Single requester 0, word B; rx_data must hold afterwards.
    data0 = 4'hB;
    push_txn(2'b01, data0, data1);
    req = 2'b01;
    wait_dones(1);
    req = 2'b00;
    step(3);
    check("rx_hold", 32'(rx_data), 32'hB);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_gnt", 32'(gnt), 32'd0);

    // Both requesting from reset: 01, 10, 01 with one IDLE cycle between.
    do_reset();
    chk_gap = 1'b1;
    data0 = 4'h3;
    data1 = 4'hC;
    repeat (3) push_txn(2'b11, data0, data1);
    req = 2'b11;
    wait_grants(3);
    req = 2'b00;
    wait_dones(3);
    chk_gap = 1'b0;
    step(2);

    // Reset in SHIFT at k=3 aborts without done.
    do_reset();
    data0 = 4'h7;
    push_txn(2'b01, data0, data1);
    req = 2'b01;
    wait_grants(1);
    step(3);
    rst = 1'b1;
    req = 2'b00;
    step(1);
    check("abort_gnt", 32'(gnt), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_shift_en", 32'(shift_en), 32'd0);
    check("abort_sdo", 32'(sdo), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_rx_data", 32'(rx_data), 32'd0);
    check("abort_state", 32'(u_dut.state_q), 32'(ST_IDLE));
    check("abort_cnt", 32'(u_dut.cnt_q), 32'd0);
    exp_q.delete();
    exp_gnt_q.delete();
    model_pref = 1'b0;
    n_grants   = 0;
    n_dones    = 0;
    rst        = 1'b0;
    step(4);
    check("abort_no_done", 32'(n_dones), 32'd0);
    data1 = 4'h5;
    push_txn(2'b10, data0, data1);
    req = 2'b10;
    wait_dones(1);
    req = 2'b00;
    step(1);

    // Request dropped and data changed after the grant.
    data0 = 4'h6;
    push_txn(2'b01, data0, data1);
    req = 2'b01;
    wait_grants(n_grants + 1);
    req   = 2'b00;
    data0 = 4'h9;
    wait_dones(n_dones + 1);
    step(1);
    check("gnt_after_done", 32'(gnt), 32'd0);

    // Random requests and words.
    for (int i = 0; i < 8; i++) begin
      r   = 2'($urandom_range(1, 3));
      rd0 = W'($urandom_range(0, 15));
      rd1 = W'($urandom_range(0, 15));
      data0 = rd0;
      data1 = rd1;
      push_txn(r, rd0, rd1);
      req = r;
      wait_dones(n_dones + 1);
      req = 2'b00;
      step(1);
    end
    step(2);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    // Single-stage chain instance.
    do_reset();
    data1_0 = 4'hA;
    req1 = 2'b01;
    t = 0;
    while (gnt1 == 2'b00 && t < TO) begin step(1); t++; end
    check("d1_grant", 32'(gnt1), 32'd1);
    t = 0;
    while (!done1 && t < TO) begin step(1); t++; end
    check("d1_latency", 32'(t), 32'(W + D1));
    check("d1_rx_data", 32'(rx1), 32'hA);
    req1 = 2'b00;
    step(3);
    check("d1_idle", 32'(busy1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
